ball_motion_ctrl: RTL and testbench

- Upstream neighbour of the VGA pixel renderer. Owns the bouncing-ball state and publishes a stable ball centre once per frame; the renderer compares that centre against the live raster.
- Watches the raster position from the sync generator and detects the frame start.
- Advances a fixed-point position through a small update sequencer, reflects off the screen bounds and flags each bounce.
- Outputs are double-buffered, so the centre never changes in the middle of a frame's active area.

---
 rtl/ball_motion_ctrl_if.sv | 24 ++
 rtl/ball_motion_ctrl.sv | 157 +++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ball_motion_ctrl_if.sv
// Raster-in / ball-centre-out bundle shared by the sync generator side and the renderer side.
// The master drives the raster position and motion controls; the slave publishes the ball state.
interface ball_motion_ctrl_if;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       pause;
    logic [7:0] speed_x;
    logic [7:0] speed_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic       bounce;

    modport master (
        output hpos, vpos, pause, speed_x, speed_y,
        input  ball_x, ball_y, dir_x, dir_y, bounce
    );

    modport slave (
        input  hpos, vpos, pause, speed_x, speed_y,
        output ball_x, ball_y, dir_x, dir_y, bounce
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Bouncing-ball state owner: one fixed-point update per frame, reflected at the screen bounds,
// with the centre published through a holding register so it never changes mid-frame.
module ball_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int RADIUS    = 20,
    parameter int INIT_X    = 320,
    parameter int INIT_Y    = 240,
    parameter int FRAC_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    ball_motion_ctrl_if.slave bus
);

    localparam int PW = 10 + FRAC_BITS;
    localparam int CW = 11 + FRAC_BITS;

    localparam logic [CW-1:0] MIN_X = CW'(RADIUS << FRAC_BITS);
    localparam logic [CW-1:0] MAX_X = CW'((H_ACTIVE - 1 - RADIUS) << FRAC_BITS);
    localparam logic [CW-1:0] MIN_Y = CW'(RADIUS << FRAC_BITS);
    localparam logic [CW-1:0] MAX_Y = CW'((V_ACTIVE - 1 - RADIUS) << FRAC_BITS);
    localparam logic [PW-1:0] POS_X0 = PW'(INIT_X << FRAC_BITS);
    localparam logic [PW-1:0] POS_Y0 = PW'(INIT_Y << FRAC_BITS);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, PUBLISH} state_t;

    typedef struct packed {
        logic [PW-1:0] pos;
        logic          dir;
        logic          hit;
    } axis_t;

    // One axis step. The extra top bit keeps pos+speed from wrapping before the bound compare.
    function automatic axis_t move_axis(input logic [PW-1:0] pos, input logic dir,
                                        input logic [7:0] spd,
                                        input logic [CW-1:0] lo, input logic [CW-1:0] hi);
        logic [CW-1:0] p;
        logic [CW-1:0] s;
        logic [CW-1:0] up;
        axis_t         r;
        p     = {1'b0, pos};
        s     = CW'(spd);
        up    = p + s;
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        if (dir) begin
            if (spd != 8'd0 && up >= hi) begin
                r.pos = hi[PW-1:0];
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = up[PW-1:0];
            end
        end else begin
            if (spd != 8'd0 && p < lo + s) begin
                r.pos = lo[PW-1:0];
                r.dir = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - PW'(spd);
            end
        end
        return r;
    endfunction

    state_t        state, state_next;
    logic          prev_zero;
    logic          at_zero;
    logic          tick;
    logic [7:0]    spd_x, spd_y;
    logic [PW-1:0] pos_x, pos_y;
    logic          dir_x, dir_y;
    logic          hit_x, hit_y;
    logic [9:0]    ball_x, ball_y;
    logic          bounce;
    axis_t         step_x, step_y;

    assign at_zero = (bus.hpos == 10'd0) && (bus.vpos == 10'd0);
    // Edge-detect the origin so a raster stalled at (0,0) still yields a single tick.
    assign tick    = at_zero && !prev_zero;

    assign step_x = move_axis(pos_x, dir_x, spd_x, MIN_X, MAX_X);
    assign step_y = move_axis(pos_y, dir_y, spd_y, MIN_Y, MAX_Y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (tick && !bus.pause) state_next = MOVE_X;
            MOVE_X:  state_next = MOVE_Y;
            MOVE_Y:  state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_zero <= 1'b0;
            spd_x     <= 8'd0;
            spd_y     <= 8'd0;
            pos_x     <= POS_X0;
            pos_y     <= POS_Y0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            hit_x     <= 1'b0;
            hit_y     <= 1'b0;
            ball_x    <= 10'(INIT_X);
            ball_y    <= 10'(INIT_Y);
            bounce    <= 1'b0;
        end else begin
            prev_zero <= at_zero;
            bounce    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tick && !bus.pause) begin
                        spd_x <= bus.speed_x;
                        spd_y <= bus.speed_y;
                    end
                end
                MOVE_X: begin
                    pos_x <= step_x.pos;
                    dir_x <= step_x.dir;
                    hit_x <= step_x.hit;
                end
                MOVE_Y: begin
                    pos_y <= step_y.pos;
                    dir_y <= step_y.dir;
                    hit_y <= step_y.hit;
                end
                PUBLISH: begin
                    ball_x <= pos_x[PW-1:FRAC_BITS];
                    ball_y <= pos_y[PW-1:FRAC_BITS];
                    bounce <= hit_x | hit_y;
                    hit_x  <= 1'b0;
                    hit_y  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ball_x = ball_x;
    assign bus.ball_y = ball_y;
    assign bus.dir_x  = dir_x;
    assign bus.dir_y  = dir_y;
    assign bus.bounce = bounce;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: hand-computed centres, bounces, pause and mid-update reset.
module tb_ball_motion_ctrl;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ball_motion_ctrl_if bus ();

    ball_motion_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one (0,0) raster sample, move off it, and return just after the publish edge E3.
    task automatic frame();
        @(negedge clk);
        bus.hpos = 10'd0;
        bus.vpos = 10'd0;
        @(negedge clk);
        bus.hpos = 10'd5;
        bus.vpos = 10'd5;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.hpos    = 10'd5;
        bus.vpos    = 10'd5;
        bus.pause   = 1'b0;
        bus.speed_x = 8'h00;
        bus.speed_y = 8'h00;
        reset       = 1'b1;

        // Reset with the clock stopped.
        #3;
        check("rst_ball_x", bus.ball_x, 10'd320);
        check("rst_ball_y", bus.ball_y, 10'd240);
        check("rst_dir_x", 10'(bus.dir_x), 10'd1);
        check("rst_dir_y", 10'(bus.dir_y), 10'd1);
        check("rst_bounce", 10'(bus.bounce), 10'd0);

        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic step, with the raster held at (0,0) for several cycles.
        bus.speed_x = 8'h20;
        bus.speed_y = 8'h10;
        @(negedge clk);
        bus.hpos = 10'd0;
        bus.vpos = 10'd0;
        repeat (4) @(negedge clk);
        check("basic_x", bus.ball_x, 10'd322);
        check("basic_y", bus.ball_y, 10'd241);
        check("basic_bounce", 10'(bus.bounce), 10'd0);
        repeat (4) @(negedge clk);
        check("hold_x", bus.ball_x, 10'd322);
        check("hold_y", bus.ball_y, 10'd241);
        bus.hpos = 10'd5;
        bus.vpos = 10'd5;

        // Half-pixel steps accumulate in the fraction.
        pulse_reset();
        bus.speed_x = 8'h08;
        bus.speed_y = 8'h00;
        frame();
        check("frac1_x", bus.ball_x, 10'd320);
        check("frac1_y", bus.ball_y, 10'd240);
        frame();
        check("frac2_x", bus.ball_x, 10'd321);
        check("frac2_y", bus.ball_y, 10'd240);
        check("frac2_bounce", 10'(bus.bounce), 10'd0);

        // Right wall at 619.
        pulse_reset();
        bus.speed_x = 8'h80;
        bus.speed_y = 8'h00;
        repeat (37) frame();
        check("right37_x", bus.ball_x, 10'd616);
        check("right37_dir", 10'(bus.dir_x), 10'd1);
        frame();
        check("right38_x", bus.ball_x, 10'd619);
        check("right38_dir", 10'(bus.dir_x), 10'd0);
        check("right38_bounce", 10'(bus.bounce), 10'd1);
        @(negedge clk);
        check("right38_bounce_drop", 10'(bus.bounce), 10'd0);
        frame();
        check("right39_x", bus.ball_x, 10'd611);
        check("right39_bounce", 10'(bus.bounce), 10'd0);

        // Bottom wall at 459.
        pulse_reset();
        bus.speed_x = 8'h00;
        bus.speed_y = 8'hF0;
        frame();
        check("bottom1_y", bus.ball_y, 10'd255);
        repeat (13) frame();
        check("bottom14_y", bus.ball_y, 10'd450);
        check("bottom14_x", bus.ball_x, 10'd320);
        frame();
        check("bottom15_y", bus.ball_y, 10'd459);
        check("bottom15_dir", 10'(bus.dir_y), 10'd0);
        check("bottom15_bounce", 10'(bus.bounce), 10'd1);

        // Pause holds everything across several ticks.
        bus.pause = 1'b1;
        repeat (3) frame();
        check("pause_y", bus.ball_y, 10'd459);
        check("pause_x", bus.ball_x, 10'd320);
        check("pause_dir_y", 10'(bus.dir_y), 10'd0);
        check("pause_bounce", 10'(bus.bounce), 10'd0);
        bus.pause = 1'b0;

        // Reset while the sequencer is in MOVE_Y.
        @(negedge clk);
        bus.hpos = 10'd0;
        bus.vpos = 10'd0;
        @(negedge clk);
        bus.hpos = 10'd5;
        bus.vpos = 10'd5;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_x", bus.ball_x, 10'd320);
        check("midrst_y", bus.ball_y, 10'd240);
        check("midrst_dir_x", 10'(bus.dir_x), 10'd1);
        check("midrst_dir_y", 10'(bus.dir_y), 10'd1);
        check("midrst_bounce", 10'(bus.bounce), 10'd0);
        repeat (3) @(negedge clk);
        check("midrst_hold_y", bus.ball_y, 10'd240);
        reset = 1'b0;
        bus.speed_x = 8'h20;
        bus.speed_y = 8'h10;
        frame();
        check("post_rst_x", bus.ball_x, 10'd322);
        check("post_rst_y", bus.ball_y, 10'd241);
        check("post_rst_bounce", 10'(bus.bounce), 10'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
